// File: rtl/pacman_soc_key_pio_pkg.sv
// Shared register map and sizing helper for the key PIO block.
package pacman_soc_key_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pacman_soc_key_debounce.sv
// Two-flop synchronizer followed by a shared debounce down-counter for the key inputs.
module pacman_soc_key_debounce
  import pacman_soc_key_pio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] stable_q,
  output logic [WIDTH-1:0] rise
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [WIDTH-1:0] sync1, sync2, prev, stable_d;
  logic [CW-1:0]    cnt;
  logic             load;

  // Bypass mode loads every cycle, giving sync2 delayed by one clock.
  always_comb begin
    load     = (DEBOUNCE_CYCLES == 0) || ((cnt == '0) && (sync2 == prev));
    stable_d = load ? sync2 : stable_q;
    rise     = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stable_q <= '0;
      cnt      <= RELOAD;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      prev     <= sync2;
      stable_q <= stable_d;
      if (sync2 != prev)
        cnt <= RELOAD;
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pacman_soc_key_pio.sv
// Avalon-MM key PIO: debounced DATA, IRQMASK, W1C EDGECAPTURE and a level interrupt.
module pacman_soc_key_pio
  import pacman_soc_key_pio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_q, rise, irq_mask, edge_cap, rd_mux, clr;
  logic             rd_en, wr_en;

  pacman_soc_key_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .stable_q (stable_q),
    .rise     (rise)
  );

  always_comb begin
    rd_en = chipselect & ~read_n;
    wr_en = chipselect & ~write_n;
    clr   = (wr_en && address == ADDR_EDGECAP) ? writedata : '0;
    case (address)
      ADDR_DATA:    rd_mux = stable_q;
      ADDR_IRQMASK: rd_mux = irq_mask;
      ADDR_EDGECAP: rd_mux = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  // Edge set is OR'd after the clear so a coincident edge survives the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK)
        irq_mask <= writedata;
      edge_cap <= (edge_cap & ~clr) | rise;
      irq      <= |(edge_cap & irq_mask);
      readdata <= rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_pacman_soc_key_pio.sv
// Directed + randomized bench; reference model decides debounce from a window of sampled inputs.
module tb_pacman_soc_key_pio;
  localparam int W  = 32;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [W-1:0] writedata = '0, in_port = '0, readdata;
  logic         irq;

  always #5 clk = ~clk;

  pacman_soc_key_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  int checks = 0, errors = 0;

  // Model state; hist[i] is in_port as seen i edges before the current one.
  logic [W-1:0] m_stable, m_edge, m_mask, m_rd;
  logic         m_irq;
  logic [W-1:0] hist[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stable = '0; m_edge = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
    hist.delete();
    repeat (DC + 3) hist.push_back('0);
  endtask

  // A new value is accepted once the last DC+1 synchronized samples agree.
  task automatic tick();
    logic [W-1:0] ns, rs, clr, nrd, nmask, nedge;
    logic         same, nirq;
    hist.push_front(in_port);
    while (hist.size() > DC + 3) void'(hist.pop_back());
    same = 1'b1;
    for (int i = 3; i <= 2 + DC; i++) if (hist[i] !== hist[2]) same = 1'b0;
    ns    = same ? hist[2] : m_stable;
    rs    = ns & ~m_stable;
    clr   = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
    nmask = (chipselect && !write_n && address == 2'd2) ? writedata : m_mask;
    nedge = (m_edge & ~clr) | rs;
    nirq  = (m_edge & m_mask) != '0;
    nrd   = '0;
    if (chipselect && !read_n)
      case (address)
        2'd0: nrd = m_stable;
        2'd2: nrd = m_mask;
        2'd3: nrd = m_edge;
        default: nrd = '0;
      endcase
    @(posedge clk); #1;
    m_stable = ns; m_edge = nedge; m_mask = nmask; m_irq = nirq; m_rd = nrd;
    chk("readdata", readdata, m_rd);
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_read(input logic [1:0] a, output logic [W-1:0] d);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
    tick();
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [W-1:0] d);
    chipselect = 1'b1; read_n = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  logic [W-1:0] d;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_readdata", readdata, '0);
    chk("reset_irq", {31'b0, irq}, '0);
    reset_n = 1'b1;
    model_reset();
    idle(2);

    // Reserved address and read-only DATA.
    do_read(2'd1, d);       chk("rsvd_read", d, '0);
    do_write(2'd0, '1);     idle(1);
    do_read(2'd0, d);       chk("data_not_written", d, '0);
    do_write(2'd1, '1);
    do_read(2'd1, d);       chk("rsvd_after_write", d, '0);

    // Short glitch is rejected.
    in_port = 32'h1; idle(2);
    in_port = 32'h0; idle(12);
    do_read(2'd0, d);       chk("glitch_data", d, '0);
    do_read(2'd3, d);       chk("glitch_edge", d, '0);

    // Held input is accepted and captured, irq masked.
    in_port = 32'h1; idle(10);
    do_read(2'd0, d);       chk("held_data", d, 32'h1);
    do_read(2'd3, d);       chk("held_edge", d, 32'h1);
    chk("masked_irq", {31'b0, irq}, '0);

    // Unmasked edge raises irq; W1C drops it one cycle later.
    do_write(2'd3, 32'h1);
    in_port = 32'h0; idle(10);
    do_write(2'd2, 32'h1);
    do_read(2'd2, d);       chk("mask_read", d, 32'h1);
    in_port = 32'h1; idle(10);
    chk("irq_set", {31'b0, irq}, 32'h1);
    do_write(2'd3, 32'h1);
    chk("irq_hold_on_clear", {31'b0, irq}, 32'h1);
    idle(1);
    chk("irq_cleared", {31'b0, irq}, '0);

    // W1C in the same cycle the edge is recorded keeps the bit.
    in_port = 32'h0; idle(10);
    do_write(2'd3, '1);
    in_port = 32'h1; idle(6);
    do_write(2'd3, 32'h1);
    do_read(2'd3, d);       chk("set_beats_clear", d, 32'h1);
    do_write(2'd3, 32'h1);

    // Reset during debounce discards the pending value.
    in_port = 32'hF; idle(3);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_readdata", readdata, '0);
    chk("midreset_irq", {31'b0, irq}, '0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    model_reset();
    do_read(2'd0, d);       chk("post_reset_data", d, '0);
    do_read(2'd2, d);       chk("post_reset_mask", d, '0);
    do_read(2'd3, d);       chk("post_reset_edge", d, '0);
    idle(DC);
    do_read(2'd0, d);       chk("post_reset_data_f", d, 32'hF);
    do_read(2'd3, d);       chk("post_reset_edge_f", d, 32'hF);

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(5) == 0) in_port = {24'b0, 8'($urandom)};
      case ($urandom_range(5))
        0, 1: do_read(2'($urandom_range(3)), d);
        2:    do_write(2'd2, $urandom);
        3:    do_write(2'd3, $urandom);
        4:    do_write(2'($urandom_range(1)), $urandom);
        default: idle(1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
